id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage directly downstream of the fetch stage. Consumes the IF/ID bundle: PC, instruction, predicted-taken flag and valid.
- Owns the 32x32 integer register file: two read ports for decode, one write port driven from writeback.
- Generates RV32I control and immediates, detects load-use hazards, and registers everything into the ID/EX pipeline register.
- A one-entry hold buffer replays an instruction stalled by a load-use hazard. It exists because fetch drops IF_ID_enable_out while stalled.

Parameters:
DATA_WIDTH, 32, register/data width
NOP_INSTR, 32'h00000013, instruction value presented downstream on a bubble

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
IF_ID_PC  in  32  PC of fetched instruction
IF_ID_Instruction  in  32  fetched instruction
IF_ID_jump_branch_taken  in  1  fetch predicted taken
IF_ID_enable_out  in  1  IF/ID bundle valid
hazard_flush  in  1  redirect; kill IF/ID, hold buffer and the ID/EX entry being written
wb_reg_write  in  1  writeback enable
wb_rd  in  5  writeback destination
wb_data  in  32  writeback data
load_use_stall  out  1  combinational; drives fetch hazard_stall
ID_EX_PC  out  32  registered PC
ID_EX_Instruction  out  32  registered instruction (NOP_INSTR on bubble)
ID_EX_rs1_data, ID_EX_rs2_data  out  32 each  operand values
ID_EX_imm  out  32  sign-extended immediate
ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5 each  register indices
ID_EX_alu_src  out  1  1 = immediate operand
ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write, ID_EX_mem_to_reg  out  1 each  memory/writeback control
ID_EX_branch, ID_EX_jump  out  1 each  control-flow class
ID_EX_jump_branch_taken  out  1  passed-through prediction
ID_EX_illegal  out  1  unsupported opcode
ID_EX_enable_out  out  1  ID/EX valid

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - All ID_EX_* outputs are 0, except ID_EX_Instruction = NOP_INSTR.
  - Hold buffer is empty.
  - All 32 registers are cleared.
- Decode source: the hold buffer if full, else the IF/ID inputs. Source is valid if the hold buffer is full or IF_ID_enable_out = 1.
- Opcode decode:
  - Supported: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
  - Any other valid opcode: ID_EX_illegal = 1, enable_out = 1, all control bits 0.
- Immediates: I, S, B, U, J formats, sign-extended from instr[31].
  - B and J immediates have bit0 = 0.
  - U immediate = {instr[31:12], 12'b0}.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write occurs at the clk edge when wb_reg_write = 1.
  - Reads are combinational.
- Load-use detection:
  - load_use_stall = valid source AND ID_EX_enable_out AND ID_EX_mem_read AND ID_EX_rd != 0 AND (ID_EX_rd == src rs1, or ID_EX_rd == src rs2 when the source uses rs2: BRANCH, STORE, OP) AND NOT hazard_flush.
  - rs1 is not used by LUI, AUIPC or JAL.
- Per edge, priority order:
  1. reset
  2. hazard_flush: hold buffer is emptied; ID/EX becomes a bubble (enable_out = 0, all control bits 0, Instruction = NOP_INSTR).
  3. load_use_stall: ID/EX becomes a bubble. If the source is the IF/ID inputs, they are captured into the hold buffer; if already held, the buffer keeps its contents.
  4. Valid source: decoded bundle is registered with enable_out = 1; hold buffer is emptied.
  5. Otherwise: bubble.
- Latency: one cycle from IF/ID valid to ID/EX valid; two cycles when stalled (one bubble, then replay).
- A stall lasts exactly one cycle. After the bubble, ID_EX_mem_read = 0, so the replay cannot re-stall.

Optional Feature:
- ID_REGFILE_BYPASS_EN
  - Defined: a same-cycle writeback is forwarded to the read ports. If wb_reg_write = 1, wb_rd != 0 and wb_rd matches rs1/rs2, that read returns wb_data.
  - Undefined: reads return the stored value only. Writeback-to-decode ordering must then be handled downstream.

Test Plan:
- Reset held 2 cycles, then released -> ID_EX_enable_out = 0, ID_EX_Instruction = 32'h00000013, load_use_stall = 0, x1..x31 read 0.
- IF/ID valid, ADDI x5,x0,-3 (32'hFFD00293), PC = 0x40 -> next cycle: enable = 1, PC = 0x40, imm = 0xFFFFFFFD, rd = 5, alu_src = 1, reg_write = 1, mem_read = 0.
- LW x6,0(x1), then ADD x7,x6,x2 on the next cycle, with fetch dropping valid on stall -> stall high 1 cycle; ID/EX shows a bubble, then ADD with rs1 = 6 one cycle later; enable pattern 1,0,1.
- hazard_flush asserted in the same cycle as load_use_stall conditions, with the hold buffer full -> stall = 0, ID/EX bubble, hold buffer empty; the held ADD is never issued.
- wb_reg_write = 1, wb_rd = 0, wb_data = 0xDEADBEEF, then decode ADD x8,x0,x0 -> rs1_data = rs2_data = 0.
- wb writes x3 = 0x12345678 in the same cycle ADD x9,x3,x3 is decoded -> rs1_data = 0x12345678 with ID_REGFILE_BYPASS_EN defined; 0 without it (previously cleared value).

Source files
------------

// File: rtl/id_stage.sv
// RV32I decode stage: register file, control/immediate decode, load-use detection,
// one-entry replay buffer and ID/EX register. Optional macro: ID_REGFILE_BYPASS_EN.
module id_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           IF_ID_PC,
    input  logic [31:0]           IF_ID_Instruction,
    input  logic                  IF_ID_jump_branch_taken,
    input  logic                  IF_ID_enable_out,
    input  logic                  hazard_flush,
    input  logic                  wb_reg_write,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  load_use_stall,
    output logic [31:0]           ID_EX_PC,
    output logic [31:0]           ID_EX_Instruction,
    output logic [DATA_WIDTH-1:0] ID_EX_rs1_data,
    output logic [DATA_WIDTH-1:0] ID_EX_rs2_data,
    output logic [31:0]           ID_EX_imm,
    output logic [4:0]            ID_EX_rs1,
    output logic [4:0]            ID_EX_rs2,
    output logic [4:0]            ID_EX_rd,
    output logic                  ID_EX_alu_src,
    output logic                  ID_EX_mem_read,
    output logic                  ID_EX_mem_write,
    output logic                  ID_EX_reg_write,
    output logic                  ID_EX_mem_to_reg,
    output logic                  ID_EX_branch,
    output logic                  ID_EX_jump,
    output logic                  ID_EX_jump_branch_taken,
    output logic                  ID_EX_illegal,
    output logic                  ID_EX_enable_out
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    logic                  r_hold_valid;
    logic [31:0]           r_hold_pc;
    logic [31:0]           r_hold_instr;
    logic                  r_hold_taken;
    logic [DATA_WIDTH-1:0] r_regs [32];

    logic                  w_src_valid;
    logic [31:0]           w_src_pc;
    logic [31:0]           w_src_instr;
    logic                  w_src_taken;
    logic [6:0]            w_opcode;
    logic [4:0]            w_rs1;
    logic [4:0]            w_rs2;
    logic [4:0]            w_rd;
    logic [31:0]           w_imm_i;
    logic [31:0]           w_imm_s;
    logic [31:0]           w_imm_b;
    logic [31:0]           w_imm_u;
    logic [31:0]           w_imm_j;
    logic [31:0]           w_imm;
    logic                  w_alu_src;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_reg_write;
    logic                  w_mem_to_reg;
    logic                  w_branch;
    logic                  w_jump;
    logic                  w_illegal;
    logic                  w_uses_rs1;
    logic                  w_uses_rs2;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic                  w_issue;

    // A held (previously stalled) instruction always takes precedence over fetch.
    always_comb begin
        w_src_valid = r_hold_valid || IF_ID_enable_out;
        w_src_pc    = r_hold_valid ? r_hold_pc    : IF_ID_PC;
        w_src_instr = r_hold_valid ? r_hold_instr : IF_ID_Instruction;
        w_src_taken = r_hold_valid ? r_hold_taken : IF_ID_jump_branch_taken;
    end

    always_comb begin
        w_opcode = w_src_instr[6:0];
        w_rd     = w_src_instr[11:7];
        w_rs1    = w_src_instr[19:15];
        w_rs2    = w_src_instr[24:20];
        w_imm_i  = {{20{w_src_instr[31]}}, w_src_instr[31:20]};
        w_imm_s  = {{20{w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]};
        w_imm_b  = {{19{w_src_instr[31]}}, w_src_instr[31], w_src_instr[7],
                    w_src_instr[30:25], w_src_instr[11:8], 1'b0};
        w_imm_u  = {w_src_instr[31:12], 12'b0};
        w_imm_j  = {{11{w_src_instr[31]}}, w_src_instr[31], w_src_instr[19:12],
                    w_src_instr[20], w_src_instr[30:21], 1'b0};
    end

    always_comb begin
        w_imm        = '0;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_illegal    = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_imm       = w_imm_u;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            OPC_JAL: begin
                w_imm       = w_imm_j;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            OPC_JALR: begin
                w_imm       = w_imm_i;
                w_alu_src   = 1'b1;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm    = w_imm_b;
                w_branch = 1'b1;
            end
            OPC_LOAD: begin
                w_imm        = w_imm_i;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                w_imm       = w_imm_s;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OPC_OPIMM: begin
                w_imm       = w_imm_i;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            OPC_OP: begin
                w_reg_write = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_uses_rs1 = !(w_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        w_uses_rs2 = w_opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    end

    always_comb begin
        w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
        w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`ifdef ID_REGFILE_BYPASS_EN
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == w_rs1) w_rs1_data = wb_data;
        if (wb_reg_write && wb_rd != 5'd0 && wb_rd == w_rs2) w_rs2_data = wb_data;
`endif
    end

    always_comb begin
        load_use_stall = w_src_valid && ID_EX_enable_out && ID_EX_mem_read &&
                         (ID_EX_rd != 5'd0) &&
                         ((w_uses_rs1 && ID_EX_rd == w_rs1) ||
                          (w_uses_rs2 && ID_EX_rd == w_rs2)) &&
                         !hazard_flush;
        w_issue = w_src_valid && !hazard_flush && !load_use_stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (wb_reg_write && wb_rd != 5'd0) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Capture only from fetch; an already-held instruction stays put while stalled.
    always_ff @(posedge clk) begin
        if (reset || hazard_flush) begin
            r_hold_valid <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
            r_hold_taken <= 1'b0;
        end else if (load_use_stall) begin
            if (!r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_pc    <= IF_ID_PC;
                r_hold_instr <= IF_ID_Instruction;
                r_hold_taken <= IF_ID_jump_branch_taken;
            end
        end else if (w_src_valid) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_issue) begin
            ID_EX_PC                <= '0;
            ID_EX_Instruction       <= NOP_INSTR;
            ID_EX_rs1_data          <= '0;
            ID_EX_rs2_data          <= '0;
            ID_EX_imm               <= '0;
            ID_EX_rs1               <= '0;
            ID_EX_rs2               <= '0;
            ID_EX_rd                <= '0;
            ID_EX_alu_src           <= 1'b0;
            ID_EX_mem_read          <= 1'b0;
            ID_EX_mem_write         <= 1'b0;
            ID_EX_reg_write         <= 1'b0;
            ID_EX_mem_to_reg        <= 1'b0;
            ID_EX_branch            <= 1'b0;
            ID_EX_jump              <= 1'b0;
            ID_EX_jump_branch_taken <= 1'b0;
            ID_EX_illegal           <= 1'b0;
            ID_EX_enable_out        <= 1'b0;
        end else begin
            ID_EX_PC                <= w_src_pc;
            ID_EX_Instruction       <= w_src_instr;
            ID_EX_rs1_data          <= w_rs1_data;
            ID_EX_rs2_data          <= w_rs2_data;
            ID_EX_imm               <= w_imm;
            ID_EX_rs1               <= w_rs1;
            ID_EX_rs2               <= w_rs2;
            ID_EX_rd                <= w_rd;
            ID_EX_alu_src           <= w_alu_src;
            ID_EX_mem_read          <= w_mem_read;
            ID_EX_mem_write         <= w_mem_write;
            ID_EX_reg_write         <= w_reg_write;
            ID_EX_mem_to_reg        <= w_mem_to_reg;
            ID_EX_branch            <= w_branch;
            ID_EX_jump              <= w_jump;
            ID_EX_jump_branch_taken <= w_src_taken;
            ID_EX_illegal           <= w_illegal;
            ID_EX_enable_out        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a behavioural decode model predicts every ID/EX
// entry; a monitor compares the registered outputs once per cycle.
module tb_id_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_ID_PC, IF_ID_Instruction;
    logic        IF_ID_jump_branch_taken, IF_ID_enable_out, hazard_flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        load_use_stall;
    logic [31:0] ID_EX_PC, ID_EX_Instruction, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic        ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write;
    logic        ID_EX_mem_to_reg, ID_EX_branch, ID_EX_jump, ID_EX_jump_branch_taken;
    logic        ID_EX_illegal, ID_EX_enable_out;

    id_stage #(.DATA_WIDTH(32), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_PC(IF_ID_PC), .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_jump_branch_taken(IF_ID_jump_branch_taken), .IF_ID_enable_out(IF_ID_enable_out),
        .hazard_flush(hazard_flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .load_use_stall(load_use_stall),
        .ID_EX_PC(ID_EX_PC), .ID_EX_Instruction(ID_EX_Instruction),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_alu_src(ID_EX_alu_src), .ID_EX_mem_read(ID_EX_mem_read),
        .ID_EX_mem_write(ID_EX_mem_write), .ID_EX_reg_write(ID_EX_reg_write),
        .ID_EX_mem_to_reg(ID_EX_mem_to_reg), .ID_EX_branch(ID_EX_branch), .ID_EX_jump(ID_EX_jump),
        .ID_EX_jump_branch_taken(ID_EX_jump_branch_taken), .ID_EX_illegal(ID_EX_illegal),
        .ID_EX_enable_out(ID_EX_enable_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_no;
        logic        valid;
        logic [31:0] pc, instr, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
        logic        branch, jump, taken, illegal;
    } exp_t;

    exp_t        q[$];
    int unsigned edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference state
    logic [31:0] m_regs [32];
    logic        m_hold_v;
    logic [31:0] m_hold_pc, m_hold_ins;
    logic        m_hold_tk;
    logic        m_ex_v, m_ex_mr;
    logic [4:0]  m_ex_rd;
    logic        m_last_stall;
    logic        cur_we;
    logic [4:0]  cur_wrd;
    logic [31:0] cur_wd;

    logic [6:0]  ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                              7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                              7'b0110011, 7'b0001111, 7'b1110011, 7'b1111111};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_REGFILE_BYPASS_EN
        if (cur_we && cur_wrd == idx) return cur_wd;
`endif
        return m_regs[idx];
    endfunction

    function automatic exp_t m_bubble();
        exp_t r;
        r = '{edge_no: 0, valid: 1'b0, pc: 32'd0, instr: NOP, rs1d: 32'd0, rs2d: 32'd0,
              imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, alu_src: 1'b0, mem_read: 1'b0,
              mem_write: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0, branch: 1'b0,
              jump: 1'b0, taken: 1'b0, illegal: 1'b0};
        return r;
    endfunction

    function automatic exp_t m_decode(input logic [31:0] pc, input logic [31:0] ins, input logic tk);
        exp_t        r;
        int          si;
        logic [31:0] sgn, ii, is, ib, iu, ij;
        r       = m_bubble();
        r.valid = 1'b1;
        r.pc    = pc;
        r.instr = ins;
        r.rd    = ins[11:7];
        r.rs1   = ins[19:15];
        r.rs2   = ins[24:20];
        r.rs1d  = m_read(r.rs1);
        r.rs2d  = m_read(r.rs2);
        r.taken = tk;
        si  = int'(ins);
        sgn = 32'(si >>> 31);
        ii  = 32'(si >>> 20);
        is  = (ii & ~32'h1F) | 32'(ins[11:7]);
        ib  = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        iu  = ins & 32'hFFFFF000;
        ij  = (sgn << 20) | (ins & 32'h000FF000) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin r.imm = iu; r.alu_src = 1; r.reg_write = 1; end
            7'b1101111: begin r.imm = ij; r.jump = 1; r.reg_write = 1; end
            7'b1100111: begin r.imm = ii; r.jump = 1; r.reg_write = 1; r.alu_src = 1; end
            7'b1100011: begin r.imm = ib; r.branch = 1; end
            7'b0000011: begin r.imm = ii; r.alu_src = 1; r.mem_read = 1; r.reg_write = 1; r.mem_to_reg = 1; end
            7'b0100011: begin r.imm = is; r.alu_src = 1; r.mem_write = 1; end
            7'b0010011: begin r.imm = ii; r.alu_src = 1; r.reg_write = 1; end
            7'b0110011: r.reg_write = 1;
            default:    r.illegal = 1;
        endcase
        return r;
    endfunction

    // One cycle of stimulus, applied at the falling edge for the next rising edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic tk, input logic fl, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wd);
        exp_t        r;
        logic        sv, stall, u1, u2;
        logic [31:0] spc, sins;
        logic        stk;
        logic [6:0]  op;
        @(negedge clk);
        IF_ID_enable_out = v; IF_ID_PC = pc; IF_ID_Instruction = ins;
        IF_ID_jump_branch_taken = tk; hazard_flush = fl;
        wb_reg_write = we; wb_rd = wrd; wb_data = wd;
        cur_we = we; cur_wrd = wrd; cur_wd = wd;
        #1;
        sv   = m_hold_v || v;
        spc  = m_hold_v ? m_hold_pc  : pc;
        sins = m_hold_v ? m_hold_ins : ins;
        stk  = m_hold_v ? m_hold_tk  : tk;
        op   = sins[6:0];
        u1   = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2   = op inside {7'b1100011, 7'b0100011, 7'b0110011};
        stall = sv && m_ex_v && m_ex_mr && (m_ex_rd != 5'd0) &&
                ((u1 && m_ex_rd == sins[19:15]) || (u2 && m_ex_rd == sins[24:20])) && !fl;
        chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, stall});
        r = m_bubble();
        if (fl) begin
            m_hold_v = 1'b0;
        end else if (stall) begin
            if (!m_hold_v) begin
                m_hold_v = 1'b1; m_hold_pc = pc; m_hold_ins = ins; m_hold_tk = tk;
            end
        end else if (sv) begin
            r = m_decode(spc, sins, stk);
            m_hold_v = 1'b0;
        end
        r.edge_no = edge_cnt + 1;
        q.push_back(r);
        m_ex_v  = r.valid;
        m_ex_mr = r.mem_read;
        m_ex_rd = r.rd;
        if (we && wrd != 5'd0) m_regs[wrd] = wd;
        m_last_stall = stall;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ins, input logic fl);
        drive(1'b1, pc, ins, 1'b0, fl, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: compares the entry predicted for the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
                e = q.pop_front();
                chk("sb_edge", edge_cnt, e.edge_no);
                chk("sb_enable", {31'd0, ID_EX_enable_out}, {31'd0, e.valid});
                chk("sb_instr", ID_EX_Instruction, e.instr);
                chk("sb_ctrl",
                    {23'd0, ID_EX_alu_src, ID_EX_mem_read, ID_EX_mem_write, ID_EX_reg_write,
                     ID_EX_mem_to_reg, ID_EX_branch, ID_EX_jump, ID_EX_illegal, ID_EX_jump_branch_taken},
                    {23'd0, e.alu_src, e.mem_read, e.mem_write, e.reg_write,
                     e.mem_to_reg, e.branch, e.jump, e.illegal, e.taken});
                if (e.valid) begin
                    chk("sb_pc", ID_EX_PC, e.pc);
                    chk("sb_imm", ID_EX_imm, e.imm);
                    chk("sb_rs1_data", ID_EX_rs1_data, e.rs1d);
                    chk("sb_rs2_data", ID_EX_rs2_data, e.rs2d);
                    chk("sb_regidx", {17'd0, ID_EX_rs1, ID_EX_rs2, ID_EX_rd}, {17'd0, e.rs1, e.rs2, e.rd});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ins, pc;
        logic        v, fl;
        reset = 1'b1;
        IF_ID_PC = '0; IF_ID_Instruction = '0; IF_ID_jump_branch_taken = 1'b0;
        IF_ID_enable_out = 1'b0; hazard_flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_hold_v = 0; m_hold_pc = 0; m_hold_ins = 0; m_hold_tk = 0;
        m_ex_v = 0; m_ex_mr = 0; m_ex_rd = 0; m_last_stall = 0;
        cur_we = 0; cur_wrd = 0; cur_wd = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_enable", {31'd0, ID_EX_enable_out}, 32'd0);
        chk("reset_instr", ID_EX_Instruction, NOP);
        chk("reset_stall", {31'd0, load_use_stall}, 32'd0);

        // Every register reads zero after reset
        for (int i = 1; i < 32; i++)
            issue(32'(i * 4), {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'b0110011}, 1'b0);

        // ADDI x5,x0,-3
        issue(32'h40, 32'hFFD00293, 1'b0);
        @(posedge clk); #1;
        chk("addi_enable", {31'd0, ID_EX_enable_out}, 32'd1);
        chk("addi_pc", ID_EX_PC, 32'h40);
        chk("addi_imm", ID_EX_imm, 32'hFFFFFFFD);
        chk("addi_rd", {27'd0, ID_EX_rd}, 32'd5);
        chk("addi_ctrl", {29'd0, ID_EX_alu_src, ID_EX_reg_write, ID_EX_mem_read}, 32'b110);

        // LW x6,0(x1) then dependent ADD x7,x6,x2: bubble, then replay
        issue(32'h44, 32'h0000A303, 1'b0);
        issue(32'h48, 32'h002303B3, 1'b0);
        chk("lu_stall_high", {31'd0, load_use_stall}, 32'd1);
        chk("lu_en0", {31'd0, ID_EX_enable_out}, 32'd1);
        @(posedge clk); #1;
        chk("lu_en1", {31'd0, ID_EX_enable_out}, 32'd0);
        idle();
        chk("lu_replay_no_stall", {31'd0, load_use_stall}, 32'd0);
        @(posedge clk); #1;
        chk("lu_en2", {31'd0, ID_EX_enable_out}, 32'd1);
        chk("lu_replay_rs1", {27'd0, ID_EX_rs1}, 32'd6);
        chk("lu_replay_instr", ID_EX_Instruction, 32'h002303B3);

        // Flush coincident with stall conditions: no stall, no capture
        issue(32'h50, 32'h0000A303, 1'b0);
        issue(32'h54, 32'h002303B3, 1'b1);
        chk("flush_stall_low", {31'd0, load_use_stall}, 32'd0);
        @(posedge clk); #1;
        chk("flush_bubble", {31'd0, ID_EX_enable_out}, 32'd0);
        idle();
        @(posedge clk); #1;
        chk("flush_no_replay", {31'd0, ID_EX_enable_out}, 32'd0);

        // Flush while the hold buffer is full: held ADD is dropped
        issue(32'h60, 32'h0000A303, 1'b0);
        issue(32'h64, 32'h002303B3, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        chk("hold_flush_bubble", {31'd0, ID_EX_enable_out}, 32'd0);
        idle();
        @(posedge clk); #1;
        chk("hold_flush_dropped", {31'd0, ID_EX_enable_out}, 32'd0);

        // Writes to x0 are ignored
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
        issue(32'h70, 32'h00000433, 1'b0);
        @(posedge clk); #1;
        chk("x0_rs1_data", ID_EX_rs1_data, 32'd0);
        chk("x0_rs2_data", ID_EX_rs2_data, 32'd0);

        // Same-cycle writeback to x3 while ADD x9,x3,x3 decodes
        drive(1'b1, 32'h74, 32'h003184B3, 1'b0, 1'b0, 1'b1, 5'd3, 32'h12345678);
        @(posedge clk); #1;
`ifdef ID_REGFILE_BYPASS_EN
        chk("wb_same_cycle", ID_EX_rs1_data, 32'h12345678);
`else
        chk("wb_same_cycle", ID_EX_rs1_data, 32'd0);
`endif
        issue(32'h78, 32'h003184B3, 1'b0);
        @(posedge clk); #1;
        chk("wb_after", ID_EX_rs2_data, 32'h12345678);

        // Randomised traffic over a small register window to provoke hazards
        pc = 32'h1000;
        for (int n = 0; n < 2000; n++) begin
            fl = ($urandom_range(0, 99) < 8);
            v  = m_last_stall ? 1'b0 : ($urandom_range(0, 99) < 80);
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 11)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive(v, pc, ins, 1'($urandom_range(0, 1)), fl,
                  ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom);
            if (v) pc = pc + 4;
        end

        repeat (3) idle();
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
